// File: rtl/food_dispenser_pkg.sv
// Shared definitions for the food dispenser: UI stage encoding, setting limits
// and the saturating up/down step used by both setting screens.
package food_dispenser_pkg;

    typedef enum logic [1:0] {
        SET_WEIGHT   = 2'd0,
        SET_INTERVAL = 2'd1,
        RUN          = 2'd2
    } stage_t;

    localparam logic [6:0] WEIGHT_MIN     = 7'd1;
    localparam logic [6:0] WEIGHT_MAX     = 7'd100;
    localparam logic [6:0] WEIGHT_RESET   = 7'd20;

    localparam logic [4:0] INTERVAL_MIN   = 5'd1;
    localparam logic [4:0] INTERVAL_MAX   = 5'd24;
    localparam logic [4:0] INTERVAL_RESET = 5'd8;

    // Simultaneous up and down cancel out; the value never leaves [lo, hi].
    function automatic logic [6:0] sat_step(
        input logic [6:0] value,
        input logic [6:0] lo,
        input logic [6:0] hi,
        input logic       up,
        input logic       down
    );
        logic [6:0] result;
        result = value;
        if (up && !down && value < hi) begin
            result = value + 7'd1;
        end else if (down && !up && value > lo) begin
            result = value - 7'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/input_conditioner.sv
// Two-flop synchronizer, level debouncer and single-edge pulse generator for
// one raw asynchronous input.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit FALLING_EDGE    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    // The debounced level strictly alternates starting from 0, so every
    // reported falling edge is necessarily preceded by an accepted rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count >= LAST) begin
                level <= sync2;
                count <= '0;
                pulse <= sync2 ^ FALLING_EDGE;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/feed_ui_scheduler.sv
// Feeder front panel: weight/interval setup screens, then a run mode that
// schedules feeds, tracks day rollover and forwards pedal presses.
module feed_ui_scheduler
    import food_dispenser_pkg::*;
#(
    parameter int SEC_PER_HOUR    = 3600,
    parameter int DAY_TICKS       = 86400,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_confirm_raw,
    input  logic       pedal_raw,
    input  logic       food_gate,
    input  logic       play_function_flag,
    output logic [6:0] set_food_weight,
    output logic [4:0] feed_interval,
    output logic       initialize_flag,
    output logic       timesup,
    output logic       newday,
    output logic       play_function_pedal,
    output logic [1:0] setup_stage
);

    localparam logic [16:0] DAY_LAST = 17'(DAY_TICKS - 1);

    stage_t      state;
    logic        up_pulse;
    logic        down_pulse;
    logic        confirm_pulse;
    logic        pedal_pulse;
    logic        gate_q;
    logic        gate_open;
    logic [16:0] interval_count;
    logic [16:0] interval_target;
    logic [16:0] count_next;
    logic [16:0] day_count;

    input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FALLING_EDGE(1'b0)) u_up (
        .clk(clk), .reset(reset), .raw(btn_up_raw), .pulse(up_pulse)
    );
    input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FALLING_EDGE(1'b0)) u_down (
        .clk(clk), .reset(reset), .raw(btn_down_raw), .pulse(down_pulse)
    );
    input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FALLING_EDGE(1'b0)) u_confirm (
        .clk(clk), .reset(reset), .raw(btn_confirm_raw), .pulse(confirm_pulse)
    );
    input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FALLING_EDGE(1'b1)) u_pedal (
        .clk(clk), .reset(reset), .raw(pedal_raw), .pulse(pedal_pulse)
    );

    assign setup_stage     = state;
    assign interval_target = 17'(feed_interval * SEC_PER_HOUR);
    assign count_next      = interval_count + 17'd1;
    // Only a real dispense (gate opening outside play mode) acknowledges a feed.
    assign gate_open       = food_gate && !gate_q && !play_function_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= SET_WEIGHT;
            set_food_weight     <= WEIGHT_RESET;
            feed_interval       <= INTERVAL_RESET;
            initialize_flag     <= 1'b0;
            timesup             <= 1'b0;
            newday              <= 1'b0;
            play_function_pedal <= 1'b0;
            interval_count      <= '0;
            day_count           <= '0;
            gate_q              <= 1'b0;
        end else begin
            gate_q              <= food_gate;
            play_function_pedal <= (state == RUN) && pedal_pulse;
            if (gate_open) begin
                timesup <= 1'b0;
            end
            case (state)
                SET_WEIGHT: begin
                    if (confirm_pulse) begin
                        state <= SET_INTERVAL;
                    end else begin
                        set_food_weight <= sat_step(set_food_weight, WEIGHT_MIN,
                                                    WEIGHT_MAX, up_pulse, down_pulse);
                    end
                end
                SET_INTERVAL: begin
                    if (confirm_pulse) begin
                        state           <= RUN;
                        initialize_flag <= 1'b1;
                        interval_count  <= '0;
                        day_count       <= '0;
                    end else begin
                        feed_interval <= 5'(sat_step({2'b00, feed_interval},
                                                     {2'b00, INTERVAL_MIN},
                                                     {2'b00, INTERVAL_MAX},
                                                     up_pulse, down_pulse));
                    end
                end
                RUN: begin
                    if (tick_1s) begin
                        // A fresh expiry outranks a same-cycle acknowledge so a feed is never lost.
                        if (count_next >= interval_target) begin
                            interval_count <= '0;
                            timesup        <= 1'b1;
                        end else begin
                            interval_count <= count_next;
                        end
                        if (day_count == DAY_LAST) begin
                            day_count <= '0;
                            newday    <= 1'b1;
                        end else begin
                            day_count <= day_count + 17'd1;
                            newday    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= SET_WEIGHT;
                    initialize_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feed_ui_scheduler.sv
// Randomized and directed bench for feed_ui_scheduler, checked every cycle
// against a behavioural model of the panel.
module tb_feed_ui_scheduler;

    localparam int SEC = 4;
    localparam int DAY = 40;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1s = 1'b0;
    logic       food_gate = 1'b0;
    logic       play_function_flag = 1'b0;
    logic [3:0] raw_v = 4'b0000;  // 0 up, 1 down, 2 confirm, 3 pedal
    logic [6:0] set_food_weight;
    logic [4:0] feed_interval;
    logic       initialize_flag;
    logic       timesup;
    logic       newday;
    logic       play_function_pedal;
    logic [1:0] setup_stage;

    int n_tests = 0;
    int n_fail = 0;
    int ped_count = 0;
    bit cmp_en = 1'b0;

    feed_ui_scheduler #(.SEC_PER_HOUR(SEC), .DAY_TICKS(DAY), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .reset(reset),
        .tick_1s(tick_1s),
        .btn_up_raw(raw_v[0]),
        .btn_down_raw(raw_v[1]),
        .btn_confirm_raw(raw_v[2]),
        .pedal_raw(raw_v[3]),
        .food_gate(food_gate),
        .play_function_flag(play_function_flag),
        .set_food_weight(set_food_weight),
        .feed_interval(feed_interval),
        .initialize_flag(initialize_flag),
        .timesup(timesup),
        .newday(newday),
        .play_function_pedal(play_function_pedal),
        .setup_stage(setup_stage)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int        m_weight, m_interval, m_stage, m_run_ticks;
    bit        m_timesup, m_newday, m_pedal, m_gate_prev;
    bit [31:0] m_hist [4];
    bit        m_level [4];
    bit        m_pulse [4];

    task automatic model_reset();
        m_weight = 20; m_interval = 8; m_stage = 0; m_run_ticks = 0;
        m_timesup = 0; m_newday = 0; m_pedal = 0; m_gate_prev = 0;
        for (int c = 0; c < 4; c++) begin
            m_hist[c] = 0; m_level[c] = 0; m_pulse[c] = 0;
        end
    endtask

    task automatic model_step();
        int        stage_before;
        bit        pu, pd, pc, feed_due;
        bit [31:0] win;
        bit [31:0] mask;
        pu = m_pulse[0]; pd = m_pulse[1]; pc = m_pulse[2];
        stage_before = m_stage;
        m_pedal = (stage_before == 2) && m_pulse[3];
        if (stage_before == 0) begin
            if (pc) m_stage = 1;
            else if (pu && !pd && m_weight < 100) m_weight++;
            else if (pd && !pu && m_weight > 1) m_weight--;
        end else if (stage_before == 1) begin
            if (pc) begin
                m_stage = 2; m_run_ticks = 0;
            end else if (pu && !pd && m_interval < 24) m_interval++;
            else if (pd && !pu && m_interval > 1) m_interval--;
        end
        feed_due = 0;
        if (stage_before == 2 && tick_1s) begin
            m_run_ticks++;
            feed_due = (m_run_ticks % (m_interval * SEC)) == 0;
            m_newday = (m_run_ticks % DAY) == 0;
        end
        if (feed_due) m_timesup = 1;
        else if (food_gate && !m_gate_prev && !play_function_flag) m_timesup = 0;
        m_gate_prev = food_gate;
        // Debounced level flips once the last DEB synchronized samples all disagree with it.
        mask = (32'd1 << DEB) - 32'd1;
        for (int c = 0; c < 4; c++) begin
            m_hist[c] = {m_hist[c][30:0], raw_v[c]};
            win = (m_hist[c] >> 2) & mask;
            m_pulse[c] = 0;
            if (!m_level[c] && win == mask) begin
                m_level[c] = 1; m_pulse[c] = (c != 3);
            end else if (m_level[c] && win == 0) begin
                m_level[c] = 0; m_pulse[c] = (c == 3);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (play_function_pedal === 1'b1) ped_count++;
        if (cmp_en) begin
            n_tests++;
            if (set_food_weight !== 7'(m_weight) || feed_interval !== 5'(m_interval) ||
                setup_stage !== 2'(m_stage) || initialize_flag !== (m_stage == 2) ||
                timesup !== m_timesup || newday !== m_newday ||
                play_function_pedal !== m_pedal) begin
                n_fail++;
                $display("FAIL model_cmp @%0t dut/model: weight %0d/%0d interval %0d/%0d stage %0d/%0d init %0d/%0d timesup %0d/%0d newday %0d/%0d pedal %0d/%0d",
                         $time, set_food_weight, m_weight, feed_interval, m_interval,
                         setup_stage, m_stage, initialize_flag, (m_stage == 2),
                         timesup, m_timesup, newday, m_newday, play_function_pedal, m_pedal);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input int dut_v, input int model_v, input int lit);
        check({name, "_dut"}, dut_v, lit);
        check({name, "_model"}, model_v, lit);
    endtask

    task automatic press(input int c);
        raw_v[c] = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        raw_v[c] = 1'b0;
        repeat (DEB + 3) @(negedge clk);
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int hold [4];

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check_both("rst_weight", set_food_weight, m_weight, 20);
        check_both("rst_interval", feed_interval, m_interval, 8);
        check_both("rst_stage", setup_stage, m_stage, 0);
        check("rst_init", initialize_flag, 0);
        check("rst_timesup", timesup, 0);
        check("rst_newday", newday, 0);
        check("rst_pedal", play_function_pedal, 0);

        repeat (5) press(1);
        check_both("weight_after_5_down", set_food_weight, m_weight, 15);
        repeat (200) press(0);
        check_both("weight_sat_100", set_food_weight, m_weight, 100);

        do_reset();
        ped_count = 0;
        raw_v[3] = 1'b1; repeat (10) @(negedge clk);
        raw_v[3] = 1'b0; repeat (10) @(negedge clk);
        check("pedal_outside_run", ped_count, 0);
        repeat (25) press(0);
        press(2);
        check_both("stage_interval", setup_stage, m_stage, 1);
        repeat (20) press(1);
        press(2);
        check_both("setup_weight", set_food_weight, m_weight, 45);
        check_both("setup_interval", feed_interval, m_interval, 1);
        check("setup_init", initialize_flag, 1);
        check("setup_stage_run", setup_stage, 2);

        repeat (3) tick();
        check("timesup_before_4", timesup, 0);
        tick();
        check_both("timesup_at_4", timesup, m_timesup, 1);
        play_function_flag = 1'b1; food_gate = 1'b1;
        repeat (2) @(negedge clk);
        check("timesup_play_gate", timesup, 1);
        food_gate = 1'b0; @(negedge clk);
        play_function_flag = 1'b0; food_gate = 1'b1;
        @(negedge clk);
        check_both("timesup_cleared", timesup, m_timesup, 0);
        food_gate = 1'b0; @(negedge clk);

        ped_count = 0;
        raw_v[3] = 1'b1; repeat (2) @(negedge clk);
        raw_v[3] = 1'b0; repeat (10) @(negedge clk);
        check("pedal_glitch", ped_count, 0);
        raw_v[3] = 1'b1; repeat (10) @(negedge clk);
        raw_v[3] = 1'b0; repeat (10) @(negedge clk);
        check("pedal_one_pulse", ped_count, 1);

        do_reset();
        press(2);
        repeat (8) press(1);
        press(2);
        repeat (39) tick();
        check("newday_before_40", newday, 0);
        food_gate = 1'b1; @(negedge clk);
        food_gate = 1'b0; @(negedge clk);
        check("timesup_cleared_39", timesup, 0);
        tick();
        check_both("newday_at_40", newday, m_newday, 1);
        check_both("timesup_at_40", timesup, m_timesup, 1);
        tick();
        check_both("newday_at_41", newday, m_newday, 0);
        repeat (19) tick();
        #2 reset = 1'b1;
        #1;
        check("arst_weight", set_food_weight, 20);
        check("arst_interval", feed_interval, 8);
        check("arst_stage", setup_stage, 0);
        check("arst_init", initialize_flag, 0);
        check("arst_timesup", timesup, 0);
        check("arst_newday", newday, 0);
        check("arst_pedal", play_function_pedal, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 4; c++) hold[c] = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                for (int c = 0; c < 4; c++) begin
                    if (hold[c] == 0) begin
                        raw_v[c] = (c == 2) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
                        hold[c] = $urandom_range(1, 8);
                    end
                    hold[c]--;
                end
                tick_1s = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) food_gate = ~food_gate;
                play_function_flag = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            raw_v = 4'b0000; tick_1s = 1'b0; food_gate = 1'b0; play_function_flag = 1'b0;
            repeat (10) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/feed_ui_scheduler.md
FEED_UI_SCHEDULER -- requirements
Module: feed_ui_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports named clk and reset.
REQ-002 The parameters SHALL be:
- SEC_PER_HOUR, default 3600, ticks per interval hour.
- DAY_TICKS, default 86400, ticks per day.
- DEBOUNCE_CYCLES, default 16, clk cycles a raw input must hold stable.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- tick_1s  in  1  one-clk strobe per second, synchronous.
- btn_up_raw  in  1  asynchronous button, high while pressed.
- btn_down_raw  in  1  asynchronous button, high while pressed.
- btn_confirm_raw  in  1  asynchronous button, high while pressed.
- pedal_raw  in  1  asynchronous pedal, high while pressed.
- food_gate  in  1  dispenser gate state.
- play_function_flag  in  1  dispenser in play mode.
- set_food_weight  out  7  target grams.
- feed_interval  out  5  hours between feeds.
- initialize_flag  out  1  setup complete.
- timesup  out  1  feed due.
- newday  out  1  day rollover.
- play_function_pedal  out  1  one pulse per full press+release.
- setup_stage  out  2  current state, for UI display.

Function
REQ-004 All raw inputs SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-005 Button events SHALL be single-cycle pulses on the debounced rising edge; the pedal event SHALL pulse play_function_pedal for one cycle on the debounced falling edge that follows a debounced rise.
REQ-006 The state machine SHALL have three states: SET_WEIGHT=0, SET_INTERVAL=1, RUN=2. setup_stage SHALL equal the current state.
REQ-007 In SET_WEIGHT:
- An up pulse SHALL increment set_food_weight, saturating at 100.
- A down pulse SHALL decrement it, saturating at 1.
- A confirm pulse SHALL move to SET_INTERVAL.
REQ-008 In SET_INTERVAL, up/down SHALL adjust feed_interval within 1..24, saturating. A confirm pulse SHALL move to RUN and clear both counters.
REQ-009 An up and a down pulse in the same cycle SHALL be ignored. Confirm SHALL take priority over up/down.
REQ-010 initialize_flag SHALL be high exactly while in RUN.
REQ-011 In RUN, buttons SHALL be ignored, set_food_weight and feed_interval SHALL be frozen, and pedal pulses SHALL be emitted. Outside RUN, play_function_pedal SHALL stay 0.
REQ-012 The interval counter (17 bits) SHALL:
- increment on each tick_1s in RUN;
- on reaching feed_interval*SEC_PER_HOUR (product width 17 bits), reset to 0 and set timesup.
REQ-013 timesup SHALL stay high until a food_gate 0->1 edge occurs with play_function_flag low. It SHALL then clear on the next cycle.
REQ-014 If the interval elapses while timesup is already high, timesup SHALL stay high. There SHALL be no queueing or counting of missed feeds.
REQ-015 The day counter (17 bits) SHALL:
- increment on each tick_1s in RUN;
- at DAY_TICKS-1, wrap to 0 and set newday;
- clear newday on the next tick_1s.
REQ-016 When both counters expire on the same tick, timesup and newday SHALL both assert.
REQ-017 A tick_1s arriving during the debounce window SHALL have no effect on button handling.

Reset
REQ-018 Reset values SHALL be:
- state = SET_WEIGHT;
- set_food_weight = 20;
- feed_interval = 8;
- initialize_flag, timesup, newday, play_function_pedal = 0;
- all counters, synchronizers and debouncers = 0.
REQ-019 A reset asserted mid-RUN SHALL return all outputs to their reset values immediately, without waiting for clk.

Structure
REQ-020 The state enum, weight limits (1, 100, 20) and interval limits (1, 24, 8) SHALL reside in the shared package food_dispenser_pkg.
REQ-021 The synchronizer+debouncer+edge detect SHALL be one sub-module, input_conditioner, instantiated four times.

Verification (SEC_PER_HOUR=4, DAY_TICKS=40, DEBOUNCE_CYCLES=3)
REQ-022 After reset: 25 up presses, confirm, 20 down presses, confirm -> set_food_weight=45, feed_interval=1, initialize_flag=1, setup_stage=2.
REQ-023 After reset, 5 down presses -> set_food_weight stays ≥1 (reaches 15). 200 up presses -> saturates at 100.
REQ-024 RUN with interval=1:
- 4 ticks -> timesup=1.
- food_gate rises with play_function_flag=1 -> timesup stays 1.
- food_gate rises with play_function_flag=0 -> timesup=0 next cycle.
REQ-025 Pedal glitch of 2 cycles -> no pulse. Pedal held 10 cycles then released -> exactly one play_function_pedal pulse after release.
REQ-026 RUN, 40 ticks:
- newday pulses high from tick 40 to tick 41;
- with interval=1, the 40th tick raises timesup and newday together;
- reset at tick 20 -> all outputs at reset values, setup_stage=0.
